// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: funct codes, FSM states, default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // True for any R-type instruction that reads or writes HI/LO.
    function automatic logic uses_hilo(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == 6'h00) &&
               ((funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
                (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO) ||
                (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU));
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide, one bit per step.
// Latency: WIDTH step cycles after load; 'last' flags the final step.
// Backpressure: none; advances only while the controlling FSM asserts step.
// Ports: load/is_div/op_a/op_b start an operation, step advances it, rem_hi/quo_lo expose
// the running product (hi:lo) or remainder/quotient, last marks the final iteration.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] rem_hi,
    output logic [WIDTH-1:0] quo_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;   // multiplicand or divisor
    logic             div_mode;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, operand};
        // Bring the next dividend bit into the partial remainder.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= is_div ? op_a : op_b;
            operand  <= is_div ? op_b : op_a;
            div_mode <= is_div;
            count    <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (div_mode) begin
                if (!div_diff[WIDTH+1]) begin
                    acc_hi <= div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Multiplier sits in acc_lo and is consumed LSB-first as the product shifts in.
                if (acc_lo[0]) begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end else begin
                    acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
                    acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
                end
            end
        end
    end

    assign rem_hi = acc_hi;
    assign quo_lo = acc_lo;
    assign last   = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO unit: iterative mult/multu/div/divu plus mthi/mtlo, with pause to the hazard unit.
// Latency: md ops WIDTH+2 cycles from the Start edge (Busy WIDTH+1 cycles); mthi/mtlo next edge.
// Backpressure: pause stalls an ID-stage HI/LO instruction until the FIX cycle; Start while Busy is ignored.
// Ports: clk/reset (async active-high), Start/Funct/OpA/OpB from EX, ID_OpCode/ID_Funct from IF/ID,
// Hi/Lo registers, Busy, pause. Build option MDU_FAST_MULT_EN: single-cycle multiplies.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [5:0]       ID_OpCode,
    input  logic [5:0]       ID_Funct,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             pause
);

    mdu_state_t state, next_state;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div_q, neg_res_q, neg_rem_q, div_zero_q;

    logic             iter_op, signed_op, is_div, a_neg, b_neg, load, step, last;
    logic [WIDTH-1:0] abs_a, abs_b, core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

    always_comb begin
        // Sign-extend for mult, zero-extend for multu; the low 2*WIDTH bits are exact either way.
        ext_a     = {{WIDTH{(Funct == FUNCT_MULT) & OpA[WIDTH-1]}}, OpA};
        ext_b     = {{WIDTH{(Funct == FUNCT_MULT) & OpB[WIDTH-1]}}, OpB};
        fast_prod = ext_a * ext_b;
    end

    assign iter_op = (Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU);
`else
    assign iter_op = (Funct == FUNCT_MULT) || (Funct == FUNCT_MULTU) ||
                     (Funct == FUNCT_DIV)  || (Funct == FUNCT_DIVU);
`endif

    always_comb begin
        signed_op = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
        is_div    = (Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU);
        a_neg     = signed_op & OpA[WIDTH-1];
        b_neg     = signed_op & OpB[WIDTH-1];
        abs_a     = a_neg ? -OpA : OpA;
        abs_b     = b_neg ? -OpB : OpB;
        load      = (state == IDLE) && Start && iter_op;
        step      = (state == CALC);
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .op_a   (abs_a),
        .op_b   (abs_b),
        .rem_hi (core_hi),
        .quo_lo (core_lo),
        .last   (last)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = CALC;
            CALC:    if (last) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sign flags are zero for unsigned ops, so the fix-up is a pass-through there.
    // -2^31 / -1 needs no special case: |q| = 2^31 and its negation wraps back to 2^31.
    always_comb begin
        prod_fix = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        quo_fix  = neg_res_q ? -core_lo : core_lo;
        rem_fix  = neg_rem_q ? -core_hi : core_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && Start) begin
                case (Funct)
                    FUNCT_MTHI: hi_q <= OpA;
                    FUNCT_MTLO: lo_q <= OpA;
`ifdef MDU_FAST_MULT_EN
                    FUNCT_MULT, FUNCT_MULTU: {hi_q, lo_q} <= fast_prod;
`endif
                    default: ;
                endcase
            end
            if (load) begin
                is_div_q   <= is_div;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (OpB == '0);
            end
            if (state == FIX) begin
                if (is_div_q) begin
                    // Divide by zero: remainder path carries |dividend|; restoring its sign
                    // returns the original OpA in Hi.
                    lo_q <= div_zero_q ? '1 : quo_fix;
                    hi_q <= rem_fix;
                end else begin
                    {hi_q, lo_q} <= prod_fix;
                end
            end
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = (state != IDLE);
    // Drops in FIX so the held mfhi/mflo reaches EX just as Hi/Lo update.
    assign pause = uses_hilo(ID_OpCode, ID_Funct) &&
                   ((state == CALC) || (Start && iter_op));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and randomized HI/LO ops against an arithmetic model.
// Latency: checks Busy length, Hi/Lo update cycle and pause window for each operation.
// Backpressure: exercises pause with HI/LO and unrelated instructions in ID.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] OpA, OpB;
    logic [5:0]  ID_OpCode, ID_Funct;
    logic [31:0] Hi, Lo;
    logic        Busy, pause;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Funct     (Funct),
        .OpA       (OpA),
        .OpB       (OpB),
        .ID_OpCode (ID_OpCode),
        .ID_Funct  (ID_Funct),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .pause     (pause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic uses_hilo_ref(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) && (fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    task automatic ref_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (fn)
            6'h18: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            6'h19: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            6'h1A: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
            6'h1B: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issue one md op with the given instruction in ID and check every observable effect.
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] id_op, input logic [5:0] id_fn, input string name);
        logic [31:0] e_hi, e_lo, old_hi, old_lo;
        logic        use_id;
        int          n;
        bit          held_ok, pause_ok;
        ref_model(fn, a, b, e_hi, e_lo);
        old_hi = m_hi;
        old_lo = m_lo;
        use_id = uses_hilo_ref(id_op, id_fn);
        ID_OpCode = id_op; ID_Funct = id_fn;
        Funct = fn; OpA = a; OpB = b; Start = 1'b1;
        #1;
        total++;
        if (pause !== use_id) begin
            bad++;
            $display("FAIL %s pause_at_issue: got %b want %b", name, pause, use_id);
        end
        step_clk();
        Start = 1'b0;
        n = 0; held_ok = 1; pause_ok = 1;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            if (Hi !== old_hi || Lo !== old_lo) held_ok = 0;
            if (pause !== (use_id && n <= 32)) pause_ok = 0;
            step_clk();
        end
        total++;
        if (n != 33) begin bad++; $display("FAIL %s busy_cycles: got %0d want 33", name, n); end
        total++;
        if (!held_ok) begin bad++; $display("FAIL %s hilo_held: changed before update, want %h:%h", name, old_hi, old_lo); end
        total++;
        if (!pause_ok) begin bad++; $display("FAIL %s pause_window: got wrong pause, want %b for 32 cycles", name, use_id); end
        total++;
        if (Hi !== e_hi) begin bad++; $display("FAIL %s hi: got %h want %h (a=%h b=%h)", name, Hi, e_hi, a, b); end
        total++;
        if (Lo !== e_lo) begin bad++; $display("FAIL %s lo: got %h want %h (a=%h b=%h)", name, Lo, e_lo, a, b); end
        total++;
        if (pause !== 1'b0) begin bad++; $display("FAIL %s pause_after: got %b want 0", name, pause); end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; Funct = 6'h00; OpA = '0; OpB = '0;
        ID_OpCode = 6'h00; ID_Funct = 6'h12;
        #3;
        total++; if (Hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", Hi); end
        total++; if (Lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", Lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL reset_pause: got %b want 0", pause); end
        step_clk(); step_clk();
        reset = 1'b0;
        step_clk();
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL idle_mflo_pause: got %b want 0", pause); end
    endtask

    task automatic test_mult();
        run_md(6'h18, 32'd7, 32'hFFFF_FFFD, 6'h00, 6'h12, "mult_7x-3");
        run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h00, 6'h10, "multu_max");
        run_md(6'h18, 32'h8000_0000, 32'h8000_0000, 6'h08, 6'h12, "mult_minxmin");
    endtask

    task automatic test_div();
        run_md(6'h1B, 32'd100, 32'd7, 6'h00, 6'h20, "divu_100_7");
        run_md(6'h1A, 32'hFFFF_FF9C, 32'd7, 6'h00, 6'h12, "div_-100_7");
        run_md(6'h1A, 32'd100, 32'hFFFF_FFF9, 6'h00, 6'h1B, "div_100_-7");
        run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 6'h00, 6'h10, "div_overflow");
    endtask

    task automatic test_div_zero();
        run_md(6'h1A, 32'd5, 32'd0, 6'h00, 6'h12, "div_5_0");
        run_md(6'h1A, 32'hFFFF_FFFB, 32'd0, 6'h00, 6'h20, "div_-5_0");
        run_md(6'h1B, 32'hDEAD_BEEF, 32'd0, 6'h00, 6'h11, "divu_x_0");
    endtask

    task automatic test_mt();
        ID_OpCode = 6'h00; ID_Funct = 6'h10;
        Funct = 6'h11; OpA = 32'h0000_1234; OpB = 32'h5555_5555; Start = 1'b1;
        #1;
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL mthi_pause: got %b want 0", pause); end
        step_clk();
        Start = 1'b0;
        m_hi = 32'h0000_1234;
        total++; if (Hi !== m_hi) begin bad++; $display("FAIL mthi_hi: got %h want %h", Hi, m_hi); end
        total++; if (Lo !== m_lo) begin bad++; $display("FAIL mthi_lo: got %h want %h", Lo, m_lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", Busy); end
        Funct = 6'h13; OpA = 32'hCAFE_F00D; Start = 1'b1;
        step_clk();
        Start = 1'b0;
        m_lo = 32'hCAFE_F00D;
        total++; if (Lo !== m_lo) begin bad++; $display("FAIL mtlo_lo: got %h want %h", Lo, m_lo); end
        total++; if (Hi !== m_hi) begin bad++; $display("FAIL mtlo_hi: got %h want %h", Hi, m_hi); end
    endtask

    task automatic test_random();
        logic [5:0]  fns [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
        logic [5:0]  ids [4] = '{6'h12, 6'h10, 6'h20, 6'h2A};
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: ;
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                2: b = '0;
                3: begin a = -32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 50)); end
                default: b = $urandom_range(1, 9);
            endcase
            run_md(fns[$urandom_range(0, 3)], a, b, 6'h00, ids[$urandom_range(0, 3)], $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        ID_OpCode = 6'h00; ID_Funct = 6'h12;
        Funct = 6'h1B; OpA = 32'd1000; OpB = 32'd3; Start = 1'b1;
        step_clk();
        Start = 1'b0;
        for (int i = 0; i < 9; i++) step_clk();
        total++; if (pause !== 1'b1) begin bad++; $display("FAIL midop_pause: got %b want 1", pause); end
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        total++; if (Hi !== 32'd0) begin bad++; $display("FAIL abort_hi: got %h want 0", Hi); end
        total++; if (Lo !== 32'd0) begin bad++; $display("FAIL abort_lo: got %h want 0", Lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
        total++; if (pause !== 1'b0) begin bad++; $display("FAIL abort_pause: got %b want 0", pause); end
        step_clk();
        reset = 1'b0;
        step_clk();
        run_md(6'h1B, 32'd1000, 32'd3, 6'h00, 6'h12, "divu_after_reset");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mt();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
